conv_sched: RTL and testbench

CONV_SCHED -- requirements
Module: conv_sched

---
 rtl/conv_pkg.sv | 14 +
 rtl/win_walker.sv | 40 ++++
 rtl/conv_sched.sv | 108 ++++++++++
 tb/tb_conv_sched.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding and default sizing for the convolution window scheduler.
package conv_pkg;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_S          = 5;
    localparam int DEF_CONV_LAT   = 20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_OUT,
        ST_FIN
    } state_t;
endpackage

// File: rtl/win_walker.sv
// win_walker: raster-order walker over valid window origins, column fastest.
// Wraps back to (0,0) when stepped past the final window so IDLE always sees origin.
module win_walker
    import conv_pkg::*;
#(
    parameter int S     = DEF_S,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     step,
    input  logic                     clear,
    output logic [$clog2(IMG_H)-1:0] row,
    output logic [$clog2(IMG_W)-1:0] col,
    output logic                     last
);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - S);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - S);

    logic w_col_end;

    assign w_col_end = (col == COL_MAX);
    assign last      = w_col_end && (row == ROW_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row <= '0;
            col <= '0;
        end else if (clear || (step && last)) begin
            row <= '0;
            col <= '0;
        end else if (step) begin
            col <= w_col_end ? '0 : col + CW'(1);
            row <= w_col_end ? row + RW'(1) : row;
        end
    end
endmodule

// File: rtl/conv_sched.sv
// conv_sched: sweeps every SxS window over the feature map, restarting the conv unit per
// window, waiting its fixed latency, and presenting each result on a valid/ready handshake.
module conv_sched
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int S          = DEF_S,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8,
    parameter int CONV_LAT   = DEF_CONV_LAT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(IMG_H)-1:0] win_row,
    output logic [$clog2(IMG_W)-1:0] win_col,
    output logic                     conv_clr,
    input  logic [DATA_WIDTH-1:0]    conv_res,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [DATA_WIDTH-1:0]    res_data,
    output logic [$clog2(IMG_H)-1:0] res_row,
    output logic [$clog2(IMG_W)-1:0] res_col
);
    localparam int CNT_W = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_step;
    logic             w_clear;
    logic             w_last;

    assign w_step  = (r_state == ST_OUT) && res_ready;
    assign w_clear = (r_state == ST_IDLE) && start;

    win_walker #(
        .S     (S),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_walker (
        .clk   (clk),
        .rst   (rst),
        .step  (w_step),
        .clear (w_clear),
        .row   (win_row),
        .col   (win_col),
        .last  (w_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            conv_clr  <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_row   <= '0;
            res_col   <= '0;
        end else begin
            done     <= 1'b0;
            conv_clr <= 1'b0;
            case (r_state)
                ST_IDLE: if (start) begin
                    r_state  <= ST_LOAD;
                    busy     <= 1'b1;
                    conv_clr <= 1'b1;
                end
                ST_LOAD: begin
                    r_state <= ST_WAIT;
                    r_cnt   <= CNT_W'(CONV_LAT - 1);
                end
                // Result is captured on the same edge that leaves WAIT.
                ST_WAIT: if (r_cnt == '0) begin
                    r_state   <= ST_OUT;
                    res_valid <= 1'b1;
                    res_data  <= conv_res;
                    res_row   <= win_row;
                    res_col   <= win_col;
                end else begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                ST_OUT: if (res_ready) begin
                    res_valid <= 1'b0;
                    if (w_last) begin
                        r_state <= ST_FIN;
                        done    <= 1'b1;
                    end else begin
                        r_state  <= ST_LOAD;
                        conv_clr <= 1'b1;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    busy      <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_conv_sched.sv
// tb_conv_sched: scoreboard bench for conv_sched in default, single-window and
// single-cycle-latency configurations; the conv unit model returns row*16+col.
`timescale 1ns/1ps
module tb_conv_sched;
    typedef struct {
        logic [2:0]  row;
        logic [2:0]  col;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    exp_t q[$];

    logic        rst_a = 1'b1, start_a = 1'b0, ready_a = 1'b0;
    logic        busy_a, done_a, clr_a, valid_a;
    logic [2:0]  wrow_a, wcol_a, rrow_a, rcol_a;
    logic [15:0] res_a, data_a;

    logic        rst_bc = 1'b1, start_b = 1'b0, ready_b = 1'b0, start_c = 1'b0, ready_c = 1'b0;
    logic        busy_b, done_b, clr_b, valid_b, busy_c, done_c, clr_c, valid_c;
    logic [2:0]  wrow_b, wcol_b, rrow_b, rcol_b, wrow_c, wcol_c, rrow_c, rcol_c;
    logic [15:0] res_b, data_b, res_c, data_c;

    assign res_a = 16'(wrow_a) * 16'd16 + 16'(wcol_a);
    assign res_b = 16'(wrow_b) * 16'd16 + 16'(wcol_b);
    assign res_c = 16'(wrow_c) * 16'd16 + 16'(wcol_c);

    conv_sched dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .busy(busy_a), .done(done_a),
        .win_row(wrow_a), .win_col(wcol_a), .conv_clr(clr_a), .conv_res(res_a),
        .res_valid(valid_a), .res_ready(ready_a), .res_data(data_a),
        .res_row(rrow_a), .res_col(rcol_a)
    );

    conv_sched #(.IMG_W(5), .IMG_H(5)) dut_b (
        .clk(clk), .rst(rst_bc), .start(start_b), .busy(busy_b), .done(done_b),
        .win_row(wrow_b), .win_col(wcol_b), .conv_clr(clr_b), .conv_res(res_b),
        .res_valid(valid_b), .res_ready(ready_b), .res_data(data_b),
        .res_row(rrow_b), .res_col(rcol_b)
    );

    conv_sched #(.CONV_LAT(1)) dut_c (
        .clk(clk), .rst(rst_bc), .start(start_c), .busy(busy_c), .done(done_c),
        .win_row(wrow_c), .win_col(wcol_c), .conv_clr(clr_c), .conv_res(res_c),
        .res_valid(valid_c), .res_ready(ready_c), .res_data(data_c),
        .res_row(rrow_c), .res_col(rcol_c)
    );

    task automatic push_map();
        q.delete();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                q.push_back('{3'(r), 3'(c), 16'(r * 16 + c)});
    endtask

    task automatic test_reset();
        logic [36:0] v;
        #2;
        rst_a  = 1'b0;
        rst_bc = 1'b0;
        #1;
        v = {busy_a, done_a, clr_a, valid_a, data_a, rrow_a, rcol_a, wrow_a, wcol_a};
        checks++;
        if (v !== '0) begin
            failures++;
            $display("FAIL reset_a outputs=%h expected 0", v);
        end
        checks++;
        if ({busy_b, done_b, clr_b, valid_b, data_b, busy_c, done_c, clr_c, valid_c, data_c} !== '0) begin
            failures++;
            $display("FAIL reset_bc outputs nonzero, expected 0");
        end
        repeat (2) @(negedge clk);
        rst_a  = 1'b1;
        rst_bc = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b0 || valid_a !== 1'b0 || clr_a !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset busy=%b valid=%b clr=%b expected 0 0 0", busy_a, valid_a, clr_a);
        end
    endtask

    task automatic test_sweep();
        int k, n, first_k, last_k, early_done, extra;
        exp_t e;
        push_map();
        @(negedge clk);
        ready_a = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        k = 1; n = 0; first_k = 0; last_k = 0; early_done = 0;
        while (q.size() != 0 && k < 1000) begin
            start_a = (k == 5);
            if (done_a) early_done++;
            if (valid_a && ready_a) begin
                e = q.pop_front();
                n++;
                if (n == 1) first_k = k;
                last_k = k;
                checks++;
                if (data_a !== e.data || rrow_a !== e.row || rcol_a !== e.col) begin
                    failures++;
                    $display("FAIL sweep_result n=%0d got data=%0d (%0d,%0d) expected data=%0d (%0d,%0d)",
                             n, data_a, rrow_a, rcol_a, e.data, e.row, e.col);
                end
            end
            @(negedge clk);
            k++;
        end
        start_a = 1'b0;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL sweep_count remaining=%0d expected 0", q.size());
        end
        checks++;
        if (first_k != 22 || last_k != 352) begin
            failures++;
            $display("FAIL sweep_timing first=%0d last=%0d expected 22 352", first_k, last_k);
        end
        checks++;
        if (early_done != 0 || done_a !== 1'b1) begin
            failures++;
            $display("FAIL sweep_done early=%0d done=%b expected 0 1", early_done, done_a);
        end
        @(negedge clk);
        checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b0 || wrow_a !== 3'd0 || wcol_a !== 3'd0) begin
            failures++;
            $display("FAIL sweep_idle done=%b busy=%b win=(%0d,%0d) expected 0 0 (0,0)", done_a, busy_a, wrow_a, wcol_a);
        end
        extra = 0;
        repeat (60) begin
            @(negedge clk);
            if (busy_a || valid_a) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL ignored_start busy_cycles=%0d expected 0", extra);
        end
    endtask

    task automatic test_backpressure();
        int k, stall, last_k, clr_next;
        exp_t e;
        push_map();
        @(negedge clk);
        ready_a = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        k = 1; stall = 0; last_k = 0; clr_next = 0;
        while (q.size() != 0 && k < 1000) begin
            if (clr_next != 0) begin
                clr_next = 0;
                checks++;
                if (clr_a !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_reload clr=%b expected 1", clr_a);
                end
            end
            if (valid_a && rrow_a == 3'd1 && rcol_a == 3'd2 && stall < 7) begin
                ready_a = 1'b0;
                stall++;
                checks++;
                if (valid_a !== 1'b1 || data_a !== 16'd18 || clr_a !== 1'b0 || wcol_a !== 3'd2) begin
                    failures++;
                    $display("FAIL bp_hold cycle=%0d valid=%b data=%0d clr=%b expected 1 18 0", stall, valid_a, data_a, clr_a);
                end
            end else begin
                ready_a = 1'b1;
            end
            if (valid_a && ready_a) begin
                e = q.pop_front();
                last_k = k;
                if (e.row == 3'd1 && e.col == 3'd2) clr_next = 1;
                checks++;
                if (data_a !== e.data || rrow_a !== e.row || rcol_a !== e.col) begin
                    failures++;
                    $display("FAIL bp_result got data=%0d (%0d,%0d) expected data=%0d (%0d,%0d)",
                             data_a, rrow_a, rcol_a, e.data, e.row, e.col);
                end
            end
            @(negedge clk);
            k++;
        end
        checks++;
        if (q.size() != 0 || last_k != 359 || stall != 7) begin
            failures++;
            $display("FAIL bp_timing remaining=%0d last=%0d stalls=%0d expected 0 359 7", q.size(), last_k, stall);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int k, wk, done_seen, first_k, n;
        logic [36:0] v;
        exp_t e;
        @(negedge clk);
        ready_a = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        k = 1; wk = 0; done_seen = 0;
        while (k < 1000 && wk < 5) begin
            if (done_a) done_seen++;
            if (busy_a && wrow_a == 3'd2 && wcol_a == 3'd1 && !clr_a && !valid_a) wk++;
            @(negedge clk);
            k++;
        end
        checks++;
        if (wk < 5) begin
            failures++;
            $display("FAIL rst_mid_reach wait_cycles=%0d expected 5", wk);
        end
        #2;
        rst_a = 1'b0;
        #1;
        v = {busy_a, done_a, clr_a, valid_a, data_a, rrow_a, rcol_a, wrow_a, wcol_a};
        checks++;
        if (v !== '0) begin
            failures++;
            $display("FAIL rst_mid_outputs outputs=%h expected 0", v);
        end
        @(negedge clk);
        rst_a = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done_a || busy_a) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            failures++;
            $display("FAIL rst_mid_no_done events=%0d expected 0", done_seen);
        end
        push_map();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        k = 1; n = 0; first_k = 0;
        while (q.size() != 0 && k < 1000) begin
            if (valid_a && ready_a) begin
                e = q.pop_front();
                n++;
                if (n == 1) first_k = k;
                checks++;
                if (data_a !== e.data || rrow_a !== e.row || rcol_a !== e.col) begin
                    failures++;
                    $display("FAIL rst_mid_result n=%0d got data=%0d (%0d,%0d) expected data=%0d (%0d,%0d)",
                             n, data_a, rrow_a, rcol_a, e.data, e.row, e.col);
                end
            end
            @(negedge clk);
            k++;
        end
        checks++;
        if (q.size() != 0 || first_k != 22 || done_a !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_restart remaining=%0d first=%0d done=%b expected 0 22 1", q.size(), first_k, done_a);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_small_map();
        int k, n, done_k, extra;
        @(negedge clk);
        ready_b = 1'b1;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        k = 1; n = 0; done_k = 0;
        while (k < 200 && done_k == 0) begin
            if (valid_b && ready_b) begin
                n++;
                checks++;
                if (data_b !== 16'd0 || rrow_b !== 3'd0 || rcol_b !== 3'd0 || k != 22) begin
                    failures++;
                    $display("FAIL small_result got data=%0d (%0d,%0d) at %0d expected 0 (0,0) at 22",
                             data_b, rrow_b, rcol_b, k);
                end
            end
            if (done_b) done_k = k;
            @(negedge clk);
            k++;
        end
        checks++;
        if (n != 1 || done_k != 23) begin
            failures++;
            $display("FAIL small_count results=%0d done_at=%0d expected 1 23", n, done_k);
        end
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid_b || busy_b || done_b) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL small_quiet cycles=%0d expected 0", extra);
        end
    endtask

    task automatic test_min_latency();
        int k, n, clr_cnt, clr_pairs, bad_gap;
        logic prev_clr;
        exp_t e;
        push_map();
        @(negedge clk);
        ready_c = 1'b1;
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        k = 1; n = 0; clr_cnt = 0; clr_pairs = 0; bad_gap = 0; prev_clr = 1'b0;
        while (q.size() != 0 && k < 500) begin
            if (clr_c) clr_cnt++;
            if (clr_c && prev_clr) clr_pairs++;
            prev_clr = clr_c;
            if (valid_c && ready_c) begin
                e = q.pop_front();
                n++;
                if (k != 3 * n) bad_gap++;
                checks++;
                if (data_c !== e.data || rrow_c !== e.row || rcol_c !== e.col) begin
                    failures++;
                    $display("FAIL lat1_result n=%0d got data=%0d (%0d,%0d) expected data=%0d (%0d,%0d)",
                             n, data_c, rrow_c, rcol_c, e.data, e.row, e.col);
                end
            end
            @(negedge clk);
            k++;
        end
        checks++;
        if (q.size() != 0 || bad_gap != 0) begin
            failures++;
            $display("FAIL lat1_spacing remaining=%0d off_slot=%0d expected 0 0", q.size(), bad_gap);
        end
        checks++;
        if (clr_cnt != 16 || clr_pairs != 0) begin
            failures++;
            $display("FAIL lat1_clr pulses=%0d back_to_back=%0d expected 16 0", clr_cnt, clr_pairs);
        end
        checks++;
        if (done_c !== 1'b1) begin
            failures++;
            $display("FAIL lat1_done done=%b expected 1", done_c);
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_backpressure();
        test_reset_mid();
        test_small_map();
        test_min_latency();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
